// File: rtl/inst_queue.sv
// inst_queue: circular instruction FIFO between fetch and dual-issue decode.
// Splits 128-bit fetch packages into per-instruction entries.
module inst_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic [127:0]             package_i,
  input  logic                     package_valid_i,
  output logic                     queue_full_o,
  output logic                     slot0_valid_o,
  output logic                     slot1_valid_o,
  output logic [31:0]              slot0_pc_o,
  output logic [31:0]              slot1_pc_o,
  output logic [31:0]              slot0_inst_o,
  output logic [31:0]              slot1_inst_o,
  output logic                     slot0_br_o,
  output logic                     slot1_br_o,
  output logic                     slot0_pt_o,
  output logic                     slot1_pt_o,
  input  logic [1:0]               deq_count_i,
  output logic [$clog2(DEPTH):0]   occupancy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        br;
    logic        pt;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            full;
  logic            accept;
  logic            v1;
  logic            v2;
  logic [CW-1:0]   enq_n;
  logic [CW-1:0]   deq_req;
  logic [CW-1:0]   deq_n;
  entry_t          e1;
  entry_t          e2;
  entry_t          first;
  entry_t          s0;
  entry_t          s1;
  logic            s0_valid;
  logic            s1_valid;
  logic            unused_bits;

  assign v1 = package_i[31];
  assign v2 = package_i[30];
  assign unused_bits = ^package_i[25:0];

  assign e1 = {package_i[127:96], package_i[95:64],
               package_i[29], package_i[28]};
  assign e2 = {package_i[127:96] + 32'd4, package_i[63:32],
               package_i[27], package_i[26]};

  // Full depends only on registered count so fetch sees no input path.
  assign full   = count > CW'(DEPTH - 2);
  assign accept = package_valid_i & ~full & ~flush_i;
  assign enq_n  = accept ? (CW'(v1) + CW'(v2)) : '0;

  assign deq_req = CW'(deq_count_i);
  assign deq_n   = (deq_req > count) ? count : deq_req;

  assign first = v1 ? e1 : e2;

  always_ff @(posedge clk) begin
    if (accept && (v1 || v2)) begin
      mem[wr_ptr] <= first;
    end
    if (accept && v1 && v2) begin
      mem[wr_ptr + AW'(1)] <= e2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + enq_n[AW-1:0];
      rd_ptr <= rd_ptr + deq_n[AW-1:0];
      count  <= count + enq_n - deq_n;
    end
  end

  assign s0       = mem[rd_ptr];
  assign s1       = mem[rd_ptr + AW'(1)];
  assign s0_valid = count != '0;
  assign s1_valid = count > CW'(1);

  assign queue_full_o  = full;
  assign occupancy_o   = count;
  assign slot0_valid_o = s0_valid;
  assign slot1_valid_o = s1_valid;

  assign slot0_pc_o   = s0_valid ? s0.pc   : '0;
  assign slot0_inst_o = s0_valid ? s0.inst : '0;
  assign slot0_br_o   = s0_valid & s0.br;
  assign slot0_pt_o   = s0_valid & s0.pt;

  assign slot1_pc_o   = s1_valid ? s1.pc   : '0;
  assign slot1_inst_o = s1_valid ? s1.inst : '0;
  assign slot1_br_o   = s1_valid & s1.br;
  assign slot1_pt_o   = s1_valid & s1.pt;

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: scoreboard bench for inst_queue (DEPTH=8).
// Expected entries are queued at drive time and compared at the slots.
module tb_inst_queue;

  localparam int DEPTH = 8;

  logic         clk;
  logic         rst;
  logic         flush_i;
  logic [127:0] package_i;
  logic         package_valid_i;
  logic         queue_full_o;
  logic         slot0_valid_o;
  logic         slot1_valid_o;
  logic [31:0]  slot0_pc_o;
  logic [31:0]  slot1_pc_o;
  logic [31:0]  slot0_inst_o;
  logic [31:0]  slot1_inst_o;
  logic         slot0_br_o;
  logic         slot1_br_o;
  logic         slot0_pt_o;
  logic         slot1_pt_o;
  logic [1:0]   deq_count_i;
  logic [3:0]   occupancy_o;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        br;
    logic        pt;
  } ent_t;

  ent_t sb[$];
  logic last_acc;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .package_i       (package_i),
    .package_valid_i (package_valid_i),
    .queue_full_o    (queue_full_o),
    .slot0_valid_o   (slot0_valid_o),
    .slot1_valid_o   (slot1_valid_o),
    .slot0_pc_o      (slot0_pc_o),
    .slot1_pc_o      (slot1_pc_o),
    .slot0_inst_o    (slot0_inst_o),
    .slot1_inst_o    (slot1_inst_o),
    .slot0_br_o      (slot0_br_o),
    .slot1_br_o      (slot1_br_o),
    .slot0_pt_o      (slot0_pt_o),
    .slot1_pt_o      (slot1_pt_o),
    .deq_count_i     (deq_count_i),
    .occupancy_o     (occupancy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mk(
    input logic [31:0] pc, input logic [31:0] i1,
    input logic [31:0] i2, input logic v1, input logic v2,
    input logic br1, input logic pt1, input logic br2,
    input logic pt2);
    return {pc, i1, i2, v1, v2, br1, pt1, br2, pt2, 26'h0};
  endfunction

  // Drive one cycle; the scoreboard is advanced to the post-edge state.
  task automatic cycle(input logic pv, input logic [127:0] p,
                       input logic [1:0] dq, input logic fl);
    int n;
    logic acc;
    ent_t e;
    package_valid_i = pv;
    package_i       = p;
    deq_count_i     = dq;
    flush_i         = fl;
    acc = pv && !fl && !(sb.size() > DEPTH - 2);
    if (fl) begin
      sb.delete();
    end else begin
      n = (int'(dq) > sb.size()) ? sb.size() : int'(dq);
      repeat (n) void'(sb.pop_front());
      if (acc && p[31]) begin
        e.pc = p[127:96]; e.inst = p[95:64];
        e.br = p[29]; e.pt = p[28];
        sb.push_back(e);
      end
      if (acc && p[30]) begin
        e.pc = p[127:96] + 32'd4; e.inst = p[63:32];
        e.br = p[27]; e.pt = p[26];
        sb.push_back(e);
      end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    package_valid_i = 1'b0;
    package_i       = '0;
    deq_count_i     = 2'd0;
    flush_i         = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    package_valid_i = 1'b0;
    package_i = '0;
    deq_count_i = 2'd0;
    flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({queue_full_o, slot0_valid_o, slot1_valid_o, occupancy_o} !== 7'd0) begin
      failures++;
      $display("FAIL reset_ctrl got full=%b v0=%b v1=%b occ=%0d want 0",
               queue_full_o, slot0_valid_o, slot1_valid_o, occupancy_o);
    end
    checks++;
    if ({slot0_pc_o, slot0_inst_o, slot1_pc_o, slot1_inst_o,
         slot0_br_o, slot0_pt_o, slot1_br_o, slot1_pt_o} !== '0) begin
      failures++;
      $display("FAIL reset_data got pc0=%h pc1=%h want 0",
               slot0_pc_o, slot1_pc_o);
    end
    rst = 1'b1;
    sb.delete();
    repeat (3) cycle(1'b0, '0, 2'd0, 1'b0);
    checks++;
    if ({queue_full_o, slot0_valid_o, slot1_valid_o, occupancy_o,
         slot0_pc_o, slot1_pc_o} !== '0) begin
      failures++;
      $display("FAIL idle got full=%b v0=%b occ=%0d pc0=%h want 0",
               queue_full_o, slot0_valid_o, occupancy_o, slot0_pc_o);
    end
  endtask

  task automatic test_basic_split;
    cycle(1'b1, mk(32'h8000_0000, 32'h1111_1111, 32'h2222_2222,
                   1, 1, 0, 1, 0, 0), 2'd0, 1'b0);
    checks++;
    if ({slot0_valid_o, slot0_pc_o, slot0_inst_o, slot0_pt_o} !==
        {1'b1, 32'h8000_0000, 32'h1111_1111, 1'b1}) begin
      failures++;
      $display("FAIL split_s0 got v=%b pc=%h inst=%h pt=%b want 1 80000000 11111111 1",
               slot0_valid_o, slot0_pc_o, slot0_inst_o, slot0_pt_o);
    end
    checks++;
    if ({slot1_valid_o, slot1_pc_o, slot1_inst_o, slot1_pt_o} !==
        {1'b1, 32'h8000_0004, 32'h2222_2222, 1'b0}) begin
      failures++;
      $display("FAIL split_s1 got v=%b pc=%h inst=%h pt=%b want 1 80000004 22222222 0",
               slot1_valid_o, slot1_pc_o, slot1_inst_o, slot1_pt_o);
    end
    checks++;
    if (occupancy_o !== 4'd2) begin
      failures++;
      $display("FAIL split_occ got %0d want 2", occupancy_o);
    end
    cycle(1'b0, '0, 2'd1, 1'b0);
    checks++;
    if ({slot0_valid_o, slot0_pc_o, slot0_inst_o, slot1_valid_o} !==
        {1'b1, 32'h8000_0004, 32'h2222_2222, 1'b0}) begin
      failures++;
      $display("FAIL deq1 got v0=%b pc=%h inst=%h v1=%b want 1 80000004 22222222 0",
               slot0_valid_o, slot0_pc_o, slot0_inst_o, slot1_valid_o);
    end
    cycle(1'b0, '0, 2'd2, 1'b0);
    checks++;
    if ({occupancy_o, slot0_valid_o, slot0_pc_o} !== 37'd0) begin
      failures++;
      $display("FAIL sat_deq got occ=%0d v0=%b pc=%h want 0 0 0",
               occupancy_o, slot0_valid_o, slot0_pc_o);
    end
  endtask

  task automatic test_v2_only;
    cycle(1'b1, mk(32'h8000_0010, 32'hDEAD_BEEF, 32'hABCD_0123,
                   0, 1, 1, 1, 1, 0), 2'd0, 1'b0);
    checks++;
    if ({occupancy_o, slot0_valid_o, slot0_pc_o, slot0_inst_o,
         slot0_br_o, slot0_pt_o, slot1_valid_o} !==
        {4'd1, 1'b1, 32'h8000_0014, 32'hABCD_0123, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL v2_only got occ=%0d pc=%h inst=%h br=%b pt=%b v1=%b want 1 80000014 abcd0123 1 0 0",
               occupancy_o, slot0_pc_o, slot0_inst_o, slot0_br_o,
               slot0_pt_o, slot1_valid_o);
    end
    cycle(1'b0, '0, 2'd1, 1'b0);
  endtask

  task automatic test_fill;
    int exp_occ;
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b1, mk(32'h0000_1000 + 32'(k * 16), 32'(k), 32'(k + 100),
                     1, 1, 0, 0, 1, 1), 2'd0, 1'b0);
      exp_occ = (2 * k > 8) ? 8 : 2 * k;
      checks++;
      if (occupancy_o !== 4'(exp_occ) || queue_full_o !== (exp_occ > 6)) begin
        failures++;
        $display("FAIL fill_%0d got occ=%0d full=%b want %0d %b", k,
                 occupancy_o, queue_full_o, exp_occ, exp_occ > 6);
      end
    end
    cycle(1'b1, mk(32'h0000_2000, 32'hAAAA_0001, 32'hAAAA_0002,
                   1, 1, 0, 0, 0, 0), 2'd2, 1'b0);
    checks++;
    if (occupancy_o !== 4'd6 || queue_full_o !== 1'b0) begin
      failures++;
      $display("FAIL full_deq got occ=%0d full=%b want 6 0",
               occupancy_o, queue_full_o);
    end
    checks++;
    if (slot0_pc_o !== 32'h0000_1020 || slot0_inst_o !== 32'd2) begin
      failures++;
      $display("FAIL full_deq_s0 got pc=%h inst=%h want 00001020 2",
               slot0_pc_o, slot0_inst_o);
    end
    cycle(1'b1, mk(32'h0000_2000, 32'hAAAA_0001, 32'hAAAA_0002,
                   1, 1, 0, 0, 0, 0), 2'd0, 1'b0);
    checks++;
    if (occupancy_o !== 4'd8 || queue_full_o !== 1'b1) begin
      failures++;
      $display("FAIL refill got occ=%0d full=%b want 8 1",
               occupancy_o, queue_full_o);
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({slot0_valid_o, slot0_pc_o, slot0_inst_o, slot0_br_o, slot0_pt_o,
           slot1_valid_o, slot1_pc_o, slot1_inst_o, slot1_br_o, slot1_pt_o} !==
          {1'b1, sb[0].pc, sb[0].inst, sb[0].br, sb[0].pt,
           1'b1, sb[1].pc, sb[1].inst, sb[1].br, sb[1].pt}) begin
        failures++;
        $display("FAIL drain_%0d got pc0=%h pc1=%h want %h %h", d,
                 slot0_pc_o, slot1_pc_o, sb[0].pc, sb[1].pc);
      end
      cycle(1'b0, '0, 2'd2, 1'b0);
    end
    checks++;
    if (occupancy_o !== 4'd0 || slot0_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL drained got occ=%0d v0=%b want 0 0",
               occupancy_o, slot0_valid_o);
    end
  endtask

  task automatic test_random_wrap;
    int pk;
    int iter;
    int bad;
    logic [127:0] p;
    pk = 0;
    iter = 0;
    bad = 0;
    p = mk({$urandom_range(0, 32'hFFFF), 2'b00}, $urandom, $urandom,
           1, 1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    while (pk < 20 && iter < 400) begin
      cycle(1'b1, p, 2'($urandom_range(0, 2)), 1'b0);
      iter++;
      if (last_acc) begin
        pk++;
        p = mk($urandom & 32'hFFFF_FFFC, $urandom, $urandom,
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom));
        p[31] = p[31] | ~p[30];
      end
      checks++;
      if (occupancy_o !== 4'(sb.size()) ||
          queue_full_o !== (sb.size() > DEPTH - 2) ||
          {slot0_valid_o, slot0_pc_o, slot0_inst_o, slot0_br_o, slot0_pt_o} !==
          ((sb.size() > 0) ?
           {1'b1, sb[0].pc, sb[0].inst, sb[0].br, sb[0].pt} : 67'd0) ||
          {slot1_valid_o, slot1_pc_o, slot1_inst_o, slot1_br_o, slot1_pt_o} !==
          ((sb.size() > 1) ?
           {1'b1, sb[1].pc, sb[1].inst, sb[1].br, sb[1].pt} : 67'd0)) begin
        failures++;
        bad++;
        if (bad < 5)
          $display("FAIL rnd_%0d got occ=%0d pc0=%h pc1=%h want occ=%0d", iter,
                   occupancy_o, slot0_pc_o, slot1_pc_o, sb.size());
      end
    end
    checks++;
    if (pk < 20) begin
      failures++;
      $display("FAIL rnd_timeout got %0d packages want 20", pk);
    end
    iter = 0;
    while (sb.size() > 0 && iter < 20) begin
      cycle(1'b0, '0, 2'd2, 1'b0);
      iter++;
    end
    checks++;
    if (occupancy_o !== 4'd0) begin
      failures++;
      $display("FAIL rnd_drain got occ=%0d want 0", occupancy_o);
    end
  endtask

  task automatic test_simul;
    cycle(1'b1, mk(32'h0000_3000, 32'hC000_0001, 32'hC000_0002,
                   1, 1, 0, 0, 0, 0), 2'd0, 1'b0);
    cycle(1'b1, mk(32'h0000_3100, 32'hC000_0003, 32'h0,
                   1, 0, 0, 0, 0, 0), 2'd0, 1'b0);
    checks++;
    if (occupancy_o !== 4'd3) begin
      failures++;
      $display("FAIL simul_pre got occ=%0d want 3", occupancy_o);
    end
    cycle(1'b1, mk(32'h0000_3200, 32'hC000_0004, 32'hC000_0005,
                   1, 1, 0, 0, 0, 0), 2'd2, 1'b0);
    checks++;
    if (occupancy_o !== 4'd3 ||
        {slot0_pc_o, slot0_inst_o, slot1_pc_o, slot1_inst_o} !==
        {32'h0000_3100, 32'hC000_0003, 32'h0000_3200, 32'hC000_0004}) begin
      failures++;
      $display("FAIL simul got occ=%0d s0=%h/%h s1=%h/%h want 3 3100/c0000003 3200/c0000004",
               occupancy_o, slot0_pc_o, slot0_inst_o, slot1_pc_o, slot1_inst_o);
    end
    cycle(1'b0, '0, 2'd2, 1'b0);
    checks++;
    if (occupancy_o !== 4'd1 || slot0_pc_o !== 32'h0000_3204 ||
        slot0_inst_o !== 32'hC000_0005) begin
      failures++;
      $display("FAIL simul_tail got occ=%0d pc=%h inst=%h want 1 00003204 c0000005",
               occupancy_o, slot0_pc_o, slot0_inst_o);
    end
    cycle(1'b0, '0, 2'd2, 1'b0);
    checks++;
    if (occupancy_o !== 4'd0) begin
      failures++;
      $display("FAIL simul_sat got occ=%0d want 0", occupancy_o);
    end
  endtask

  task automatic test_flush;
    cycle(1'b1, mk(32'h0000_4000, 32'h1, 32'h2, 1, 1, 0, 0, 0, 0), 2'd0, 1'b0);
    cycle(1'b1, mk(32'h0000_4010, 32'h3, 32'h4, 1, 1, 0, 0, 0, 0), 2'd0, 1'b0);
    cycle(1'b1, mk(32'h0000_4020, 32'h5, 32'h0, 1, 0, 0, 0, 0, 0), 2'd0, 1'b0);
    checks++;
    if (occupancy_o !== 4'd5) begin
      failures++;
      $display("FAIL flush_pre got occ=%0d want 5", occupancy_o);
    end
    cycle(1'b1, mk(32'h0000_5000, 32'h7, 32'h8, 1, 1, 0, 0, 0, 0), 2'd1, 1'b1);
    checks++;
    if ({occupancy_o, slot0_valid_o, slot1_valid_o, queue_full_o} !== 7'd0) begin
      failures++;
      $display("FAIL flush got occ=%0d v0=%b v1=%b full=%b want 0",
               occupancy_o, slot0_valid_o, slot1_valid_o, queue_full_o);
    end
    cycle(1'b1, mk(32'h0000_6000, 32'h9999_0000, 32'h0,
                   1, 0, 1, 1, 0, 0), 2'd0, 1'b0);
    checks++;
    if ({occupancy_o, slot0_valid_o, slot0_pc_o, slot0_inst_o,
         slot0_br_o, slot0_pt_o} !==
        {4'd1, 1'b1, 32'h0000_6000, 32'h9999_0000, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL post_flush got occ=%0d pc=%h inst=%h want 1 00006000 99990000",
               occupancy_o, slot0_pc_o, slot0_inst_o);
    end
  endtask

  task automatic test_async_reset;
    cycle(1'b1, mk(32'h0000_7000, 32'h1, 32'h2, 1, 1, 0, 0, 0, 0), 2'd0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({occupancy_o, slot0_valid_o, slot0_pc_o} !== 37'd0) begin
      failures++;
      $display("FAIL async_rst got occ=%0d v0=%b pc=%h want 0",
               occupancy_o, slot0_valid_o, slot0_pc_o);
    end
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, mk(32'h0000_7100, 32'h5, 32'h0, 1, 0, 0, 0, 0, 0), 2'd0, 1'b0);
    checks++;
    if (occupancy_o !== 4'd1 || slot0_pc_o !== 32'h0000_7100) begin
      failures++;
      $display("FAIL after_rst got occ=%0d pc=%h want 1 00007100",
               occupancy_o, slot0_pc_o);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    last_acc = 1'b0;
    test_reset();
    test_basic_split();
    test_v2_only();
    test_fill();
    test_random_wrap();
    test_simul();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
